// File: rtl/t_dlyass_tx.sv
// rtl/t_dlyass_tx.sv - burst transmitter of incrementing (a,b) word pairs over a valid/ready handshake
module t_dlyass_tx #(
  parameter int W      = 32,
  parameter int NWORDS = 4,
  parameter int A0     = 22,
  parameter int B0     = 33,
  parameter int STEP   = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_a,
  output logic [W-1:0] out_b,
  output logic         out_last,
  output logic         busy,
  output logic         done,
  output logic [7:0]   count
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  localparam logic [W-1:0] A0_W     = W'(A0);
  localparam logic [W-1:0] B0_W     = W'(B0);
  localparam logic [W-1:0] STEP_W   = W'(STEP);
  localparam logic [7:0]   LAST_IDX = 8'(NWORDS - 1);
  localparam logic         ONE_WORD = (NWORDS == 1);

  state_t state, state_nxt;
  logic   xfer;
  logic   load;

  assign xfer      = out_valid && out_ready;
  assign load      = (state != SEND) && start;
  assign out_valid = (state == SEND);
  assign busy      = (state == SEND);
  assign done      = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // start is only honoured outside SEND, so a request during the final transfer is dropped
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SEND;
      SEND:    if (xfer && out_last) state_nxt = DONE;
      DONE:    if (start) state_nxt = SEND;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_a    <= '0;
      out_b    <= '0;
      out_last <= 1'b0;
      count    <= 8'd0;
    end else if (load) begin
      out_a    <= A0_W;
      out_b    <= B0_W;
      out_last <= ONE_WORD;
      count    <= 8'd0;
    end else if (xfer) begin
      // count holds pairs already accepted, so count+1 is the index of the next pair
      out_a    <= out_a + STEP_W;
      out_b    <= out_b + STEP_W;
      out_last <= ((count + 8'd1) == LAST_IDX);
      count    <= count + 8'd1;
    end
  end

endmodule

// File: tb/tb_t_dlyass_tx.sv
// tb/tb_t_dlyass_tx.sv - directed self-checking bench for t_dlyass_tx
module tb_t_dlyass_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        start_d = 1'b0, ready_d = 1'b0;
  logic        valid_d, last_d, busy_d, done_d;
  logic [31:0] a_d, b_d;
  logic [7:0]  count_d;

  logic        start_w = 1'b0, ready_w = 1'b0;
  logic        valid_w, last_w, busy_w, done_w;
  logic [7:0]  a_w, b_w;
  logic [7:0]  count_w;

  logic        start_n = 1'b0, ready_n = 1'b0;
  logic        valid_n, last_n, busy_n, done_n;
  logic [31:0] a_n, b_n;
  logic [7:0]  count_n;

  t_dlyass_tx u_dut (
    .clk(clk), .rst_n(rst_n), .start(start_d), .out_valid(valid_d), .out_ready(ready_d),
    .out_a(a_d), .out_b(b_d), .out_last(last_d), .busy(busy_d), .done(done_d), .count(count_d)
  );

  t_dlyass_tx #(.W(8), .NWORDS(4), .A0(254), .B0(33), .STEP(1)) u_w8 (
    .clk(clk), .rst_n(rst_n), .start(start_w), .out_valid(valid_w), .out_ready(ready_w),
    .out_a(a_w), .out_b(b_w), .out_last(last_w), .busy(busy_w), .done(done_w), .count(count_w)
  );

  t_dlyass_tx #(.NWORDS(1)) u_n1 (
    .clk(clk), .rst_n(rst_n), .start(start_n), .out_valid(valid_n), .out_ready(ready_n),
    .out_a(a_n), .out_b(b_n), .out_last(last_n), .busy(busy_n), .done(done_n), .count(count_n)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({valid_d, last_d, busy_d, done_d, count_d, a_d, b_d} !== 76'd0) begin
      errors++;
      $display("FAIL reset_default got v=%b l=%b bz=%b dn=%b c=%0d a=%0d b=%0d want all 0",
               valid_d, last_d, busy_d, done_d, count_d, a_d, b_d);
    end
    checks++;
    if ({valid_w, last_w, busy_w, done_w, count_w, a_w, b_w} !== 28'd0 ||
        {valid_n, last_n, busy_n, done_n, count_n, a_n, b_n} !== 76'd0) begin
      errors++;
      $display("FAIL reset_variants got w:v=%b a=%0d n:v=%b a=%0d want 0", valid_w, a_w, valid_n, a_n);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic_burst();
    start_d = 1'b1;
    ready_d = 1'b1;
    step();
    start_d = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({valid_d, busy_d, done_d, a_d, b_d, last_d, count_d} !==
          {1'b1, 1'b1, 1'b0, 32'(22 + i), 32'(33 + i), (i == 3), 8'(i)}) begin
        errors++;
        $display("FAIL basic_pair%0d got v=%b bz=%b a=%0d b=%0d l=%b c=%0d want v=1 a=%0d b=%0d l=%b c=%0d",
                 i, valid_d, busy_d, a_d, b_d, last_d, count_d, 22 + i, 33 + i, i == 3, i);
      end
      step();
    end
    checks++;
    if ({valid_d, busy_d, done_d, count_d} !== {3'b001, 8'd4}) begin
      errors++;
      $display("FAIL basic_done got v=%b bz=%b dn=%b c=%0d want v=0 bz=0 dn=1 c=4",
               valid_d, busy_d, done_d, count_d);
    end
  endtask

  task automatic test_stall();
    int idx = 0;
    int cyc = 0;
    start_d = 1'b1;
    ready_d = 1'b0;
    step();
    start_d = 1'b0;
    while (idx < 4 && cyc < 40) begin
      checks++;
      if ({valid_d, a_d, b_d, last_d} !== {1'b1, 32'(22 + idx), 32'(33 + idx), (idx == 3)}) begin
        errors++;
        $display("FAIL stall_cyc%0d got v=%b a=%0d b=%0d l=%b want v=1 a=%0d b=%0d l=%b",
                 cyc, valid_d, a_d, b_d, last_d, 22 + idx, 33 + idx, idx == 3);
      end
      ready_d = (cyc % 3 == 0);
      step();
      if (ready_d) idx++;
      cyc++;
    end
    ready_d = 1'b0;
    checks++;
    if (idx != 4 || {valid_d, done_d, count_d} !== {2'b01, 8'd4}) begin
      errors++;
      $display("FAIL stall_done got idx=%0d v=%b dn=%b c=%0d want idx=4 v=0 dn=1 c=4",
               idx, valid_d, done_d, count_d);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_a [4];
    exp_a[0] = 8'd254; exp_a[1] = 8'd255; exp_a[2] = 8'd0; exp_a[3] = 8'd1;
    start_w = 1'b1;
    ready_w = 1'b1;
    step();
    start_w = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({valid_w, a_w, b_w, last_w} !== {1'b1, exp_a[i], 8'(33 + i), (i == 3)}) begin
        errors++;
        $display("FAIL wrap_pair%0d got v=%b a=%0d b=%0d l=%b want v=1 a=%0d b=%0d l=%b",
                 i, valid_w, a_w, b_w, last_w, exp_a[i], 33 + i, i == 3);
      end
      step();
    end
    checks++;
    if ({valid_w, done_w, count_w} !== {2'b01, 8'd4}) begin
      errors++;
      $display("FAIL wrap_done got v=%b dn=%b c=%0d want v=0 dn=1 c=4", valid_w, done_w, count_w);
    end
  endtask

  task automatic test_reset_mid_burst();
    start_d = 1'b1;
    ready_d = 1'b1;
    step();
    start_d = 1'b0;
    step();
    step();
    checks++;
    if ({valid_d, a_d, count_d} !== {1'b1, 32'd24, 8'd2}) begin
      errors++;
      $display("FAIL midrst_pre got v=%b a=%0d c=%0d want v=1 a=24 c=2", valid_d, a_d, count_d);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({valid_d, last_d, busy_d, done_d, count_d, a_d, b_d} !== 76'd0) begin
      errors++;
      $display("FAIL midrst_async got v=%b bz=%b c=%0d a=%0d b=%0d want all 0",
               valid_d, busy_d, count_d, a_d, b_d);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (valid_d !== 1'b0 || busy_d !== 1'b0) begin
        errors++;
        $display("FAIL midrst_quiet%0d got v=%b bz=%b want 0", i, valid_d, busy_d);
      end
    end
    start_d = 1'b1;
    step();
    start_d = 1'b0;
    checks++;
    if ({valid_d, a_d, b_d, count_d} !== {1'b1, 32'd22, 32'd33, 8'd0}) begin
      errors++;
      $display("FAIL midrst_restart got v=%b a=%0d b=%0d c=%0d want v=1 a=22 b=33 c=0",
               valid_d, a_d, b_d, count_d);
    end
    for (int i = 0; i < 4; i++) step();
    checks++;
    if ({done_d, count_d} !== {1'b1, 8'd4}) begin
      errors++;
      $display("FAIL midrst_finish got dn=%b c=%0d want dn=1 c=4", done_d, count_d);
    end
  endtask

  task automatic test_single_word();
    start_n = 1'b1;
    ready_n = 1'b1;
    step();
    checks++;
    if ({valid_n, a_n, b_n, last_n, count_n} !== {1'b1, 32'd22, 32'd33, 1'b1, 8'd0}) begin
      errors++;
      $display("FAIL single_pair got v=%b a=%0d b=%0d l=%b c=%0d want v=1 a=22 b=33 l=1 c=0",
               valid_n, a_n, b_n, last_n, count_n);
    end
    step();
    checks++;
    if ({valid_n, busy_n, done_n, count_n} !== {3'b001, 8'd1}) begin
      errors++;
      $display("FAIL single_done got v=%b bz=%b dn=%b c=%0d want v=0 bz=0 dn=1 c=1",
               valid_n, busy_n, done_n, count_n);
    end
    step();
    checks++;
    if ({valid_n, a_n, b_n, last_n, count_n} !== {1'b1, 32'd22, 32'd33, 1'b1, 8'd0}) begin
      errors++;
      $display("FAIL single_restart got v=%b a=%0d b=%0d l=%b c=%0d want v=1 a=22 b=33 l=1 c=0",
               valid_n, a_n, b_n, last_n, count_n);
    end
    start_n = 1'b0;
    step();
    checks++;
    if ({valid_n, done_n, count_n} !== {2'b01, 8'd1}) begin
      errors++;
      $display("FAIL single_redone got v=%b dn=%b c=%0d want v=0 dn=1 c=1", valid_n, done_n, count_n);
    end
  endtask

  task automatic test_start_in_send();
    int pairs = 0;
    int cyc = 0;
    start_d = 1'b1;
    ready_d = 1'b1;
    step();
    start_d = 1'b0;
    while (valid_d && cyc < 20) begin
      checks++;
      if (a_d !== 32'(22 + pairs)) begin
        errors++;
        $display("FAIL sendstart_pair%0d got a=%0d want %0d", pairs, a_d, 22 + pairs);
      end
      start_d = (pairs == 1) || last_d;
      step();
      pairs++;
      cyc++;
    end
    start_d = 1'b0;
    checks++;
    if (pairs != 4 || {valid_d, done_d, count_d} !== {2'b01, 8'd4}) begin
      errors++;
      $display("FAIL sendstart_len got pairs=%0d v=%b dn=%b c=%0d want pairs=4 v=0 dn=1 c=4",
               pairs, valid_d, done_d, count_d);
    end
    step();
    checks++;
    if ({valid_d, done_d} !== 2'b01) begin
      errors++;
      $display("FAIL sendstart_hold got v=%b dn=%b want v=0 dn=1", valid_d, done_d);
    end
  endtask

  initial begin
    test_reset();
    test_basic_burst();
    test_stall();
    test_wrap();
    test_reset_mid_burst();
    test_single_word();
    test_start_in_send();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
